// File: rtl/motor602_cmd_seq.sv
// Operator command sequencer for the 3-phase bridge: debounced push-buttons drive
// setpoints and a start/stop/reverse state machine with speed ramping and dead-time.
module motor602_cmd_seq #(
  parameter int DB_CYCLES = 10000,
  parameter int SPD_MIN   = 8,
  parameter int SPD_MAX   = 200,
  parameter int SPD_INIT  = 64,
  parameter int SPD_STEP  = 4,
  parameter int PWR_MAX   = 240,
  parameter int PWR_INIT  = 128,
  parameter int PWR_STEP  = 8,
  parameter int RAMP_DIV  = 1000,
  parameter int DEAD_CYC  = 5000
) (
  input  logic       clkI,
  input  logic       nRstI,
  input  logic       m3startI,
  input  logic       m3forceStopI,
  input  logic       m3invRotateI,
  input  logic       m3speedINCi,
  input  logic       m3speedDECi,
  input  logic       m3powerINCi,
  input  logic       m3powerDECi,
  output logic       runEnO,
  output logic       dirO,
  output logic [7:0] speedCurO,
  output logic [7:0] speedSetO,
  output logic [7:0] powerO,
  output logic [2:0] stateO,
  output logic       busyO
);

  localparam int NB      = 7;
  localparam int B_START = 0;
  localparam int B_FSTOP = 1;
  localparam int B_INV   = 2;
  localparam int B_SINC  = 3;
  localparam int B_SDEC  = 4;
  localparam int B_PINC  = 5;
  localparam int B_PDEC  = 6;
  localparam int DB_W    = $clog2(DB_CYCLES + 1);
  localparam int TMR_TOP = (RAMP_DIV > DEAD_CYC) ? RAMP_DIV : DEAD_CYC;
  localparam int TMR_W   = $clog2(TMR_TOP + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, RAMP_UP = 3'd1, RUN = 3'd2, RAMP_DOWN = 3'd3, DEAD = 3'd4, FSTOP = 3'd5
  } state_t;

  // Add a signed offset and clamp into [lo, hi]; covers every setpoint and ramp step.
  function automatic logic [7:0] sat_step(input int val, input int delta, input int lo, input int hi);
    int r;
    r = val + delta;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return 8'(r);
  endfunction

  logic [NB-1:0]   raw;
  logic [NB-1:0]   sync1_q, sync2_q, acc_q, accPrev_q, press_q;
  logic [DB_W-1:0] dbCnt_q [NB];

  assign raw = {m3powerDECi, m3powerINCi, m3speedDECi, m3speedINCi,
                m3invRotateI, m3forceStopI, m3startI};

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      acc_q     <= '0;
      accPrev_q <= '0;
      press_q   <= '0;
      for (int i = 0; i < NB; i++) dbCnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      accPrev_q <= acc_q;
      press_q   <= acc_q & ~accPrev_q;
      for (int i = 0; i < NB; i++) begin
        if (sync2_q[i] == acc_q[i]) begin
          dbCnt_q[i] <= '0;
        end else if (dbCnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
          dbCnt_q[i] <= '0;
          acc_q[i]   <= sync2_q[i];
        end else begin
          dbCnt_q[i] <= dbCnt_q[i] + 1'b1;
        end
      end
    end
  end

  state_t           state_q, state_d;
  logic             runEn_q, runEn_d, dir_q, dir_d, rev_q, rev_d;
  logic [7:0]       cur_q, cur_d, set_q, set_d, pwr_q, pwr_d, upNxt;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tick, deadDone;

  assign tick     = (tmr_q == TMR_W'(RAMP_DIV - 1));
  assign deadDone = (tmr_q == TMR_W'(DEAD_CYC - 1));

  always_comb begin
    state_d = state_q;
    runEn_d = runEn_q;
    dir_d   = dir_q;
    rev_d   = rev_q;
    cur_d   = cur_q;
    set_d   = set_q;
    pwr_d   = pwr_q;
    upNxt   = sat_step(int'(cur_q), SPD_STEP, 0, int'(set_q));
    tmr_d   = (state_q != DEAD && tick) ? '0 : tmr_q + 1'b1;

    if (state_q != FSTOP) begin
      if (press_q[B_SINC] && !press_q[B_SDEC])
        set_d = sat_step(int'(set_q), SPD_STEP, SPD_MIN, SPD_MAX);
      else if (press_q[B_SDEC] && !press_q[B_SINC])
        set_d = sat_step(int'(set_q), -SPD_STEP, SPD_MIN, SPD_MAX);
      if (press_q[B_PINC] && !press_q[B_PDEC])
        pwr_d = sat_step(int'(pwr_q), PWR_STEP, 0, PWR_MAX);
      else if (press_q[B_PDEC] && !press_q[B_PINC])
        pwr_d = sat_step(int'(pwr_q), -PWR_STEP, 0, PWR_MAX);
    end

    case (state_q)
      IDLE: begin
        if (press_q[B_START]) begin
          state_d = RAMP_UP;
          cur_d   = 8'(SPD_MIN);
          runEn_d = 1'b1;
        end else if (press_q[B_INV]) begin
          dir_d = ~dir_q;
        end
      end
      RAMP_UP: begin
        if (press_q[B_START]) begin
          state_d = RAMP_DOWN;
        end else if (press_q[B_INV]) begin
          state_d = RAMP_DOWN;
          rev_d   = 1'b1;
        end else if (tick) begin
          cur_d = upNxt;
          if (upNxt == set_q) state_d = RUN;
        end
      end
      RUN: begin
        if (press_q[B_START]) begin
          state_d = RAMP_DOWN;
        end else if (press_q[B_INV]) begin
          state_d = RAMP_DOWN;
          rev_d   = 1'b1;
        end else if (tick) begin
          if (cur_q < set_q)      cur_d = upNxt;
          else if (cur_q > set_q) cur_d = sat_step(int'(cur_q), -SPD_STEP, int'(set_q), 255);
        end
      end
      RAMP_DOWN: begin
        if (press_q[B_START] && rev_q) rev_d = 1'b0;
        if (tick) begin
          if (cur_q == 8'(SPD_MIN)) begin
            state_d = DEAD;
            runEn_d = 1'b0;
            cur_d   = '0;
          end else begin
            cur_d = sat_step(int'(cur_q), -SPD_STEP, SPD_MIN, 255);
          end
        end
      end
      DEAD: begin
        if (deadDone) begin
          if (rev_q) begin
            dir_d   = ~dir_q;
            rev_d   = 1'b0;
            state_d = RAMP_UP;
            cur_d   = 8'(SPD_MIN);
            runEn_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FSTOP: begin
        if (!acc_q[B_FSTOP]) state_d = DEAD;
      end
      default: state_d = IDLE;
    endcase

    // Emergency stop overrides whatever the state decided this cycle.
    if (press_q[B_FSTOP]) begin
      state_d = FSTOP;
      runEn_d = 1'b0;
      cur_d   = '0;
      rev_d   = 1'b0;
    end

    if (state_d != state_q) tmr_d = '0;
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      state_q <= IDLE;
      runEn_q <= 1'b0;
      dir_q   <= 1'b0;
      rev_q   <= 1'b0;
      cur_q   <= '0;
      set_q   <= 8'(SPD_INIT);
      pwr_q   <= 8'(PWR_INIT);
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      runEn_q <= runEn_d;
      dir_q   <= dir_d;
      rev_q   <= rev_d;
      cur_q   <= cur_d;
      set_q   <= set_d;
      pwr_q   <= pwr_d;
      tmr_q   <= tmr_d;
    end
  end

  assign runEnO    = runEn_q;
  assign dirO      = dir_q;
  assign speedCurO = cur_q;
  assign speedSetO = set_q;
  assign powerO    = pwr_q;
  assign stateO    = state_q;
  assign busyO     = (state_q == RAMP_UP) || (state_q == RAMP_DOWN) ||
                     (state_q == DEAD)    || (state_q == FSTOP);

endmodule

// File: tb/tb_motor602_cmd_seq.sv
// Directed bench for motor602_cmd_seq with short debounce, ramp and dead-time settings.
module tb_motor602_cmd_seq;

  localparam int B_START = 0;
  localparam int B_FSTOP = 1;
  localparam int B_INV   = 2;
  localparam int B_SINC  = 3;
  localparam int B_SDEC  = 4;
  localparam int B_PINC  = 5;
  localparam int B_PDEC  = 6;

  logic       clkI = 1'b0;
  logic       nRstI = 1'b0;
  logic       m3startI = 1'b0, m3forceStopI = 1'b0, m3invRotateI = 1'b0;
  logic       m3speedINCi = 1'b0, m3speedDECi = 1'b0, m3powerINCi = 1'b0, m3powerDECi = 1'b0;
  logic       runEnO, dirO, busyO;
  logic [7:0] speedCurO, speedSetO, powerO;
  logic [2:0] stateO;

  int nChk  = 0;
  int nPass = 0;

  motor602_cmd_seq #(.DB_CYCLES(4), .RAMP_DIV(8), .DEAD_CYC(16)) dut (
    .clkI(clkI), .nRstI(nRstI),
    .m3startI(m3startI), .m3forceStopI(m3forceStopI), .m3invRotateI(m3invRotateI),
    .m3speedINCi(m3speedINCi), .m3speedDECi(m3speedDECi),
    .m3powerINCi(m3powerINCi), .m3powerDECi(m3powerDECi),
    .runEnO(runEnO), .dirO(dirO), .speedCurO(speedCurO), .speedSetO(speedSetO),
    .powerO(powerO), .stateO(stateO), .busyO(busyO)
  );

  always #5 clkI = ~clkI;

  task automatic chk(input string tag, input int obs, input int exp);
    nChk++;
    if (obs == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_START: m3startI     = v;
      B_FSTOP: m3forceStopI = v;
      B_INV:   m3invRotateI = v;
      B_SINC:  m3speedINCi  = v;
      B_SDEC:  m3speedDECi  = v;
      B_PINC:  m3powerINCi  = v;
      default: m3powerDECi  = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    repeat (10) @(negedge clkI);
    set_btn(b, 1'b0);
    repeat (10) @(negedge clkI);
  endtask

  task automatic press_n(input int b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  task automatic wait_state(input string tag, input int s, input int budget);
    int n = 0;
    while (int'(stateO) != s && n < budget) begin
      @(negedge clkI);
      n++;
    end
    chk(tag, int'(stateO), s);
  endtask

  task automatic wait_run(input string tag, input logic v, input int budget);
    int n = 0;
    while (runEnO != v && n < budget) begin
      @(negedge clkI);
      n++;
    end
    chk(tag, int'(runEnO), int'(v));
  endtask

  task automatic wait_cur(input string tag, input int v, input int budget);
    int n = 0;
    while (int'(speedCurO) != v && n < budget) begin
      @(negedge clkI);
      n++;
    end
    chk(tag, int'(speedCurO), v);
  endtask

  initial begin
    int n;
    int prevSt;
    int prevRun;

    repeat (3) @(negedge clkI);
    chk("rst_run", int'(runEnO), 0);
    chk("rst_dir", int'(dirO), 0);
    chk("rst_cur", int'(speedCurO), 0);
    chk("rst_set", int'(speedSetO), 64);
    chk("rst_pwr", int'(powerO), 128);
    chk("rst_state", int'(stateO), 0);
    chk("rst_busy", int'(busyO), 0);
    nRstI = 1'b1;
    repeat (3) @(negedge clkI);

    // 1: start, ramp 8 -> 64 in steps of 4 every 8 cycles
    m3startI = 1'b1;
    wait_run("t1_run", 1'b1, 40);
    m3startI = 1'b0;
    chk("t1_cur0", int'(speedCurO), 8);
    chk("t1_state_up", int'(stateO), 1);
    chk("t1_busy_up", int'(busyO), 1);
    repeat (7) @(negedge clkI);
    chk("t1_cur_before_tick", int'(speedCurO), 8);
    @(negedge clkI);
    chk("t1_ramp_1", int'(speedCurO), 12);
    for (int k = 2; k <= 14; k++) begin
      repeat (8) @(negedge clkI);
      chk($sformatf("t1_ramp_%0d", k), int'(speedCurO), 8 + 4 * k);
    end
    chk("t1_state_run", int'(stateO), 2);
    chk("t1_busy_run", int'(busyO), 0);

    // 2: setpoint saturation and tracking
    press_n(B_SINC, 10);
    chk("t2_set104", int'(speedSetO), 104);
    press_n(B_SINC, 30);
    chk("t2_set_max", int'(speedSetO), 200);
    wait_cur("t2_cur200", 200, 400);
    press_n(B_SDEC, 60);
    chk("t2_set_min", int'(speedSetO), 8);
    wait_cur("t2_cur8", 8, 600);
    chk("t2_state", int'(stateO), 2);
    press_n(B_PDEC, 15);
    chk("t2_pwr8", int'(powerO), 8);
    press_n(B_PDEC, 2);
    chk("t2_pwr0", int'(powerO), 0);
    press_n(B_PINC, 31);
    chk("t2_pwr_max", int'(powerO), 240);
    press_n(B_SINC, 14);
    chk("t2_set64", int'(speedSetO), 64);
    wait_cur("t2_cur64", 64, 400);

    // 3: reversal through ramp-down and dead-time
    m3invRotateI = 1'b1;
    wait_state("t3_rdown", 3, 30);
    m3invRotateI = 1'b0;
    chk("t3_dir_hold", int'(dirO), 0);
    chk("t3_run_hold", int'(runEnO), 1);
    wait_run("t3_off", 1'b0, 200);
    chk("t3_dead_state", int'(stateO), 4);
    chk("t3_dead_cur", int'(speedCurO), 0);
    chk("t3_dead_dir", int'(dirO), 0);
    n = 0;
    while (runEnO == 1'b0 && n < 100) begin
      n++;
      @(negedge clkI);
    end
    chk("t3_dead_len", n, 16);
    chk("t3_dir_rev", int'(dirO), 1);
    chk("t3_restart_cur", int'(speedCurO), 8);
    chk("t3_restart_state", int'(stateO), 1);
    wait_state("t3_run", 2, 200);
    chk("t3_run_cur", int'(speedCurO), 64);

    // 4: forced stop during ramp-up
    press(B_START);
    wait_state("t4_idle", 0, 400);
    m3startI = 1'b1;
    wait_state("t4_rampup", 1, 40);
    m3startI = 1'b0;
    repeat (20) @(negedge clkI);
    m3forceStopI = 1'b1;
    n = 0;
    prevSt = int'(stateO);
    prevRun = int'(runEnO);
    while (int'(stateO) != 5 && n < 30) begin
      prevSt = int'(stateO);
      prevRun = int'(runEnO);
      @(negedge clkI);
      n++;
    end
    chk("t4_fstop", int'(stateO), 5);
    chk("t4_prev_state", prevSt, 1);
    chk("t4_prev_run", prevRun, 1);
    chk("t4_run_off", int'(runEnO), 0);
    chk("t4_cur0", int'(speedCurO), 0);
    chk("t4_busy", int'(busyO), 1);
    press(B_SINC);
    chk("t4_set_frozen", int'(speedSetO), 64);
    chk("t4_hold", int'(stateO), 5);
    m3forceStopI = 1'b0;
    wait_state("t4_dead", 4, 30);
    n = 0;
    while (int'(stateO) == 4 && n < 100) begin
      n++;
      @(negedge clkI);
    end
    chk("t4_dead_len", n, 16);
    chk("t4_idle_end", int'(stateO), 0);
    chk("t4_dir_kept", int'(dirO), 1);

    // 5: glitch rejection, simultaneous INC/DEC, direction toggle in IDLE
    m3startI = 1'b1;
    repeat (3) @(negedge clkI);
    m3startI = 1'b0;
    repeat (20) @(negedge clkI);
    chk("t5_glitch_state", int'(stateO), 0);
    chk("t5_glitch_run", int'(runEnO), 0);
    m3speedINCi = 1'b1;
    m3speedDECi = 1'b1;
    repeat (10) @(negedge clkI);
    m3speedINCi = 1'b0;
    m3speedDECi = 1'b0;
    repeat (10) @(negedge clkI);
    chk("t5_incdec", int'(speedSetO), 64);
    press(B_INV);
    chk("t5_dir0", int'(dirO), 0);
    press(B_INV);
    chk("t5_dir1", int'(dirO), 1);
    chk("t5_idle", int'(stateO), 0);

    // 6: asynchronous reset while running at 120
    press(B_START);
    press_n(B_SINC, 14);
    chk("t6_set120", int'(speedSetO), 120);
    wait_cur("t6_cur120", 120, 400);
    chk("t6_run", int'(stateO), 2);
    #2 nRstI = 1'b0;
    #1;
    chk("t6_rst_run", int'(runEnO), 0);
    chk("t6_rst_dir", int'(dirO), 0);
    chk("t6_rst_cur", int'(speedCurO), 0);
    chk("t6_rst_set", int'(speedSetO), 64);
    chk("t6_rst_pwr", int'(powerO), 128);
    chk("t6_rst_state", int'(stateO), 0);
    chk("t6_rst_busy", int'(busyO), 0);
    repeat (2) @(negedge clkI);
    nRstI = 1'b1;
    repeat (2) @(negedge clkI);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
